if_stage: RTL

//  Instruction fetch stage of the NPC pipeline. Sits directly upstream of the IF/ID

---
 rtl/if_stage_if.sv | 40 ++++
 rtl/if_stage.sv | 90 +++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/response plus the
// IF -> ID valid / ready_go / allow_in handshake.
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [63:0] i_pc;
  logic [31:0] i_inst;
  logic        if_valid;
  logic        if_ready_go;
  logic        id_allow_in;

  modport master (
    output imem_req_valid,
    output imem_addr,
    output i_pc,
    output i_inst,
    output if_valid,
    output if_ready_go,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    input  id_allow_in
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    input  i_pc,
    input  i_inst,
    input  if_valid,
    input  if_ready_go,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    output id_allow_in
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem read in flight,
// buffers the returned word and offers {pc, inst} to ID.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus,
  input  logic        redirect,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [63:0] pc_next;
  logic [63:0] buf_pc;
  logic [31:0] buf_inst;
  logic        drop;
  logic [63:0] tgt;

  assign tgt = redirect_pc & ~64'h3;

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_addr      = pc & ~64'h3;
  assign bus.i_pc           = buf_pc;
  assign bus.i_inst         = buf_inst;
  assign bus.if_ready_go    = (state == HOLD);
  // A same-cycle redirect squashes the buffered inst before ID sees it.
  assign bus.if_valid       = (state == HOLD) && !redirect;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pc_next  <= RESET_PC;
      drop     <= 1'b0;
      buf_pc   <= RESET_PC;
      buf_inst <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) pc <= tgt;
          state <= REQ;
        end
        REQ: begin
          // Issued address stays put; the target waits in pc_next.
          if (redirect) begin
            pc_next <= tgt;
            drop    <= 1'b1;
          end
          if (bus.imem_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (bus.imem_resp_valid) begin
            if (redirect || drop) begin
              pc    <= redirect ? tgt : pc_next;
              drop  <= 1'b0;
              state <= REQ;
            end else begin
              buf_inst <= bus.imem_resp_data;
              buf_pc   <= pc;
              state    <= HOLD;
            end
          end else if (redirect) begin
            pc_next <= tgt;
            drop    <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc    <= tgt;
            state <= REQ;
          end else if (bus.id_allow_in) begin
            pc    <= pc + 64'd4;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
